// File: rtl/mioc_bist_pkg.sv
// -----------------------------------------------------------------------------
// mioc_bist_pkg
// Shared definitions for the MIOC 2-input test-gate BIST sequencer:
//   - state_t   : sequencer state encoding (IDLE/SETTLE/SAMPLE/DONE)
//   - GATE_*    : gate_sel values selecting the expected truth table
//   - exp_z()   : expected gate output for a given selector and input pair
// -----------------------------------------------------------------------------
package mioc_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic GATE_NAND2 = 1'b0;
    localparam logic GATE_NOR2  = 1'b1;

    // a = pattern bit 1 (dut_in1), b = pattern bit 0 (dut_in2)
    function automatic logic exp_z(input logic sel, input logic a, input logic b);
        return (sel == GATE_NOR2) ? ~(a | b) : ~(a & b);
    endfunction

endpackage

// File: rtl/mioc_bist_sync.sv
// -----------------------------------------------------------------------------
// mioc_bist_sync
// Two-flop synchronizer for the test-gate output, both flops reset to 0.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high
//   d    in  asynchronous input
//   q    out synchronized output (2-cycle delay)
// -----------------------------------------------------------------------------
module mioc_bist_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mioc_gate_bist_ctrl
// BIST sequencer for one MIOC NAND2/NOR2 test gate. Walks patterns 00..11 for
// LOOPS passes, holds each pattern for a settle window, samples the gate
// output in a single SAMPLE cycle and accumulates per-pattern fail bits and a
// saturating mismatch count.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        run request (IDLE only), synchronous abort
//   gate_sel            0 = NAND2 expected, 1 = NOR2 expected (latched at start)
//   dut_in1, dut_in2    gate inputs (pattern bit 1, bit 0)
//   dut_z               gate output
//   busy, done, pass    status; done is a one-cycle pulse
//   fail_vec, err_count results of the last run, held until the next start
// Build option: MIOC_BIST_SYNC_EN inserts a 2-flop synchronizer on dut_z and
// stretches the settle window by 2 cycles to cover its latency.
// -----------------------------------------------------------------------------
module mioc_gate_bist_ctrl
    import mioc_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int LOOPS         = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             gate_sel,
    output logic             dut_in1,
    output logic             dut_in2,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_vec,
    output logic [ERR_W-1:0] err_count
);

`ifdef MIOC_BIST_SYNC_EN
    localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
    localparam int CNT_W  = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_LEN - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        pat;
    logic [1:0]        pat_nxt;
    logic [LOOP_W-1:0] loop_idx;
    logic              sel_q;
    logic              z_cmp;
    logic              mismatch;

`ifdef MIOC_BIST_SYNC_EN
    mioc_bist_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_z),
        .q   (z_cmp)
    );
`else
    assign z_cmp = dut_z;
`endif

    assign pat_nxt  = pat + 2'd1;
    assign mismatch = (z_cmp != exp_z(sel_q, pat[1], pat[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pat       <= '0;
            loop_idx  <= '0;
            sel_q     <= GATE_NAND2;
            dut_in1   <= 1'b0;
            dut_in2   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        sel_q     <= gate_sel;
                        fail_vec  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        pat       <= '0;
                        loop_idx  <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        dut_in1 <= 1'b0;
                        dut_in2 <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        dut_in1 <= 1'b0;
                        dut_in2 <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        if (mismatch) begin
                            fail_vec[pat] <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                        end
                        // Gate inputs only move here, so they stay stable
                        // through every settle window.
                        if (pat != 2'd3) begin
                            pat     <= pat_nxt;
                            dut_in1 <= pat_nxt[1];
                            dut_in2 <= pat_nxt[0];
                            state   <= ST_SETTLE;
                        end else if (loop_idx != LOOP_LAST) begin
                            loop_idx <= loop_idx + LOOP_W'(1);
                            pat      <= '0;
                            dut_in1  <= 1'b0;
                            dut_in2  <= 1'b0;
                            state    <= ST_SETTLE;
                        end else begin
                            // err_count is still pre-update here, so fold in
                            // this cycle's compare.
                            pass    <= (err_count == '0) && !mismatch;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            dut_in1 <= 1'b0;
                            dut_in2 <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mioc_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mioc_gate_bist_ctrl
// Table-driven bench for mioc_gate_bist_ctrl. Two instances share the control
// inputs: SETTLE_CYCLES=4 with LOOPS=1 and with LOOPS=3. Each drives its own
// behavioural gate model selected by zmode. Honours MIOC_BIST_SYNC_EN for the
// expected latencies.
// -----------------------------------------------------------------------------
module tb_mioc_gate_bist_ctrl;

    localparam int SC = 4;
`ifdef MIOC_BIST_SYNC_EN
    localparam int LAT1 = 1 + 4 * 1 * (SC + 3);
    localparam int LAT3 = 1 + 4 * 3 * (SC + 3);
`else
    localparam int LAT1 = 1 + 4 * 1 * (SC + 1);
    localparam int LAT3 = 1 + 4 * 3 * (SC + 1);
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_sel = 1'b0;
    int         zmode = 0;

    logic       in1_a, in2_a, z_a, busy_a, done_a, pass_a;
    logic [3:0] fv_a;
    logic [7:0] err_a;
    logic       in1_b, in2_b, z_b, busy_b, done_b, pass_b;
    logic [3:0] fv_b;
    logic [7:0] err_b;
    logic       dly_a = 1'b1;
    logic       dly_b = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mioc_gate_bist_ctrl #(.SETTLE_CYCLES(SC), .LOOPS(1), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
        .dut_in1(in1_a), .dut_in2(in2_a), .dut_z(z_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .fail_vec(fv_a), .err_count(err_a)
    );

    mioc_gate_bist_ctrl #(.SETTLE_CYCLES(SC), .LOOPS(3), .ERR_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_z(z_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail_vec(fv_b), .err_count(err_b)
    );

    // zmode: 0 NAND2, 1 stuck-at-1, 2 NAND2 delayed one cycle, 3 NOR2, 4 stuck-at-0
    function automatic logic model_z(input int mode, input logic a, input logic b, input logic dly);
        case (mode)
            0:       return ~(a & b);
            1:       return 1'b1;
            2:       return dly;
            3:       return ~(a | b);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        dly_a <= ~(in1_a & in2_a);
        dly_b <= ~(in1_b & in2_b);
    end

    assign z_a = model_z(zmode, in1_a, in2_a, dly_a);
    assign z_b = model_z(zmode, in1_b, in2_b, dly_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       sel;
        int         mode;
        logic       pass;
        logic [3:0] fv;
        int         err1;
        int         err3;
    } vec_t;

    vec_t vecs[7];

    // One full run on both instances; checks latency, results and pulse width.
    task automatic run(input vec_t v, input string tag);
        int n  = 0;
        int n1 = 0;
        int n3 = 0;
        gate_sel = v.sel;
        zmode    = v.mode;
        @(negedge clk);
        start = 1'b1;
        while ((n1 == 0 || n3 == 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n1 != 0 && n == n1 + 1) check({tag, " done1 width"}, done_a, 0);
            if (done_a && n1 == 0) begin
                n1 = n;
                check({tag, " pass1"}, pass_a, v.pass);
                check({tag, " fv1"}, fv_a, v.fv);
                check({tag, " err1"}, err_a, v.err1);
                check({tag, " busy1 at done"}, busy_a, 0);
            end
            if (done_b && n3 == 0) begin
                n3 = n;
                check({tag, " pass3"}, pass_b, v.pass);
                check({tag, " fv3"}, fv_b, v.fv);
                check({tag, " err3"}, err_b, v.err3);
            end
        end
        check({tag, " latency1"}, n1, LAT1);
        check({tag, " latency3"}, n3, LAT3);
        @(negedge clk);
        check({tag, " done3 width"}, done_b, 0);
        check({tag, " pass1 held"}, pass_a, v.pass);
        check({tag, " dut_in idle"}, {in1_a, in2_a, in1_b, in2_b}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int cnt;
        vecs[0] = '{1'b0, 0, 1'b1, 4'b0000, 0, 0};
        vecs[1] = '{1'b0, 1, 1'b0, 4'b1000, 1, 3};
        vecs[2] = '{1'b1, 0, 1'b0, 4'b0110, 2, 6};
        vecs[3] = '{1'b0, 2, 1'b1, 4'b0000, 0, 0};
        vecs[4] = '{1'b1, 3, 1'b1, 4'b0000, 0, 0};
        vecs[5] = '{1'b0, 3, 1'b0, 4'b0110, 2, 6};
        vecs[6] = '{1'b1, 4, 1'b0, 4'b0001, 1, 3};

        // reset state
        repeat (3) @(negedge clk);
        check("reset outs", {in1_a, in2_a, busy_a, done_a, pass_a, fv_a, err_a}, 0);
        check("reset outs3", {in1_b, in2_b, busy_b, done_b, pass_b, fv_b, err_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));

        // abort mid-run keeps partial results; stuck-at-0 fails pattern 0
        gate_sel = 1'b0;
        zmode    = 4;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("abort pre busy", busy_a, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", {busy_a, busy_b}, 0);
        check("abort dut_in", {in1_a, in2_a, in1_b, in2_b}, 0);
        check("abort done", {done_a, done_b}, 0);
        check("abort partial fv", fv_a, 4'b0001);
        check("abort partial err", err_a, 1);
        check("abort pass", pass_a, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_a || done_b || busy_a) seen = 1'b1;
        end
        check("abort no done", seen, 0);

        // start and abort together in IDLE: no run, results untouched
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", busy_a, 0);
        check("start+abort err kept", err_a, 1);

        run(vecs[0], "post-abort");

        // async reset mid-settle
        gate_sel = 1'b0;
        zmode    = 4;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("pre-rst pattern", {busy_a, in1_a, in2_a, err_a}, {1'b1, 1'b0, 1'b1, 8'd1});
        #2 rst = 1'b1;
        #1;
        check("rst async outs", {in1_a, in2_a, busy_a, done_a, pass_a, fv_a, err_a}, 0);
        check("rst async outs3", {in1_b, in2_b, busy_b, done_b, pass_b, fv_b, err_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start held high: one run, IDLE for a cycle, then a new run
        gate_sel = 1'b0;
        zmode    = 0;
        start    = 1'b1;
        cnt      = 0;
        while (!done_a && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("held latency", cnt, LAT1);
        check("held pass", pass_a, 1);
        @(negedge clk);
        check("held idle gap", {busy_a, done_a}, 0);
        @(negedge clk);
        check("held restart", busy_a, 1);
        check("held dut3 single run", busy_b, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("held cleanup", {busy_a, busy_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
